// File: rtl/id_issue_if.sv
// ID-stage issue bus: IF handoff, EX issue handshake, flush, writeback and status.
interface id_issue_if #(
    parameter int XLEN   = 32,
    parameter int PERF_W = 16
);
    logic              if_valid;
    logic [XLEN-1:0]   if_instr;
    logic              id_ready;
    logic              issue_valid;
    logic [XLEN-1:0]   issue_instr;
    logic              issue_ready;
    logic              flush;
    logic              wb_en;
    logic [4:0]        wb_rd;
    logic [31:0]       sb_busy;
    logic [PERF_W-1:0] stall_cnt;

    modport master (
        output if_valid, if_instr, issue_ready, flush, wb_en, wb_rd,
        input  id_ready, issue_valid, issue_instr, sb_busy, stall_cnt
    );

    modport slave (
        input  if_valid, if_instr, issue_ready, flush, wb_en, wb_rd,
        output id_ready, issue_valid, issue_instr, sb_busy, stall_cnt
    );
endinterface

// File: rtl/id_issue_ctrl.sv
// ID issue controller: one-entry hold register, 32-entry write scoreboard, stall counter.
// Optional macro ID_WB_BYPASS_EN lets a waiting instruction issue in its operand's writeback cycle.
module id_issue_ctrl #(
    parameter int XLEN   = 32,
    parameter int PERF_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    id_issue_if.slave  bus
);
    typedef enum logic [1:0] {S_EMPTY, S_READY, S_STALL, S_DRAIN} state_t;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    logic              r_hold;
    logic [XLEN-1:0]   r_instr;
    logic [31:0]       r_busy;
    logic [PERF_W-1:0] r_cnt;

    logic [4:0]  w_opc, w_rs1, w_rs2, w_rd;
    logic        w_use1, w_use2, w_wr, w_ser;
    logic [31:0] w_busy_chk, w_set, w_clr, w_busy_nxt;
    logic        w_hazard, w_drain, w_issue_valid, w_fire, w_id_ready, w_accept, w_stall;
    state_t      w_state;

    assign w_opc = r_instr[6:2];
    assign w_rd  = r_instr[11:7];
    assign w_rs1 = r_instr[19:15];
    assign w_rs2 = r_instr[24:20];

    always_comb begin
        w_use1 = 1'b0;
        w_use2 = 1'b0;
        w_wr   = 1'b0;
        w_ser  = 1'b0;
        case (w_opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL: w_wr = 1'b1;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                w_use1 = 1'b1;
                w_wr   = 1'b1;
            end
            OPC_OP: begin
                w_use1 = 1'b1;
                w_use2 = 1'b1;
                w_wr   = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                w_use1 = 1'b1;
                w_use2 = 1'b1;
            end
            OPC_MISC_MEM, OPC_SYSTEM: w_ser = 1'b1;
            default: ;
        endcase
    end

    assign w_clr = (bus.wb_en && bus.wb_rd != 5'd0) ? (32'd1 << bus.wb_rd) : 32'd0;

`ifdef ID_WB_BYPASS_EN
    // Register file writes through, so a register retiring this cycle is already readable.
    assign w_busy_chk = r_busy & ~w_clr;
`else
    assign w_busy_chk = r_busy;
`endif

    assign w_hazard = (w_use1 && w_rs1 != 5'd0 && w_busy_chk[w_rs1]) ||
                      (w_use2 && w_rs2 != 5'd0 && w_busy_chk[w_rs2]);
    assign w_drain  = w_ser && (r_busy != 32'd0);

    always_comb begin
        w_state = S_EMPTY;
        if (r_hold) begin
            if (w_drain)       w_state = S_DRAIN;
            else if (w_hazard) w_state = S_STALL;
            else               w_state = S_READY;
        end
    end

    assign w_issue_valid = (w_state == S_READY) && !bus.flush;
    assign w_fire        = w_issue_valid && bus.issue_ready;
    assign w_id_ready    = (!r_hold || w_fire) && !bus.flush;
    assign w_accept      = bus.if_valid && w_id_ready;
    // Back-pressure from EX is not a stall; only hazard and drain cycles count.
    assign w_stall       = ((w_state == S_STALL) || (w_state == S_DRAIN)) && !bus.flush;

    // Set wins over a same-cycle clear; x0 never becomes busy.
    always_comb begin
        w_set = 32'd0;
        if (w_fire && w_wr && w_rd != 5'd0) w_set = 32'd1 << w_rd;
        w_busy_nxt    = (r_busy & ~w_clr) | w_set;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold  <= 1'b0;
            r_instr <= '0;
            r_busy  <= '0;
            r_cnt   <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_stall && r_cnt != '1) r_cnt <= r_cnt + PERF_W'(1);
            if (bus.flush) begin
                r_hold <= 1'b0;
            end else if (w_accept) begin
                r_hold  <= 1'b1;
                r_instr <= bus.if_instr;
            end else if (w_fire) begin
                r_hold <= 1'b0;
            end
        end
    end

    assign bus.id_ready    = w_id_ready;
    assign bus.issue_valid = w_issue_valid;
    assign bus.issue_instr = r_instr;
    assign bus.sb_busy     = r_busy;
    assign bus.stall_cnt   = r_cnt;
endmodule

// File: tb/tb_id_issue_ctrl.sv
// Bench for id_issue_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_id_issue_ctrl;
    localparam int XLEN   = 32;
    localparam int PERF_W = 16;
    localparam int CNT_MAX = (1 << PERF_W) - 1;

    localparam logic [4:0] O_LOAD = 5'b00000, O_MISC = 5'b00011, O_OPIMM = 5'b00100,
                           O_AUIPC = 5'b00101, O_STORE = 5'b01000, O_OP = 5'b01100,
                           O_LUI = 5'b01101, O_BR = 5'b11000, O_JALR = 5'b11001,
                           O_JAL = 5'b11011, O_SYS = 5'b11100, O_OTHER = 5'b10101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    id_issue_if #(.XLEN(XLEN), .PERF_W(PERF_W)) bus ();
    id_issue_ctrl #(.XLEN(XLEN), .PERF_W(PERF_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model state
    bit          m_hold;
    logic [31:0] m_instr;
    bit          m_busy [32];
    int          m_cnt;
    bit          e_iv, e_idr, e_fire, e_stall;

    function automatic logic [31:0] mk(logic [4:0] opc, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, opc, 2'b11};
    endfunction

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic bit reads1(logic [4:0] o);
        return o inside {O_JALR, O_LOAD, O_OPIMM, O_OP, O_BR, O_STORE};
    endfunction
    function automatic bit reads2(logic [4:0] o);
        return o inside {O_OP, O_BR, O_STORE};
    endfunction
    function automatic bit writes(logic [4:0] o);
        return o inside {O_LUI, O_AUIPC, O_JAL, O_JALR, O_LOAD, O_OPIMM, O_OP};
    endfunction

    function automatic bit reg_pending(logic [4:0] r);
`ifdef ID_WB_BYPASS_EN
        if (bus.wb_en && bus.wb_rd == r) return 1'b0;
`endif
        return (r != 5'd0) && m_busy[r];
    endfunction

    task automatic drive(bit ifv, logic [31:0] ins, bit rdy, bit fl, bit wbe, logic [4:0] wbrd);
        logic [4:0] o;
        bit haz, any;
        bus.if_valid = ifv; bus.if_instr = ins; bus.issue_ready = rdy;
        bus.flush = fl; bus.wb_en = wbe; bus.wb_rd = wbrd;
        #1;
        o   = m_instr[6:2];
        haz = (reads1(o) && reg_pending(m_instr[19:15])) || (reads2(o) && reg_pending(m_instr[24:20]));
        any = busy_vec() != 32'd0;
        e_iv    = m_hold && !haz && !((o == O_MISC || o == O_SYS) && any) && !fl;
        e_fire  = e_iv && rdy;
        e_idr   = (!m_hold || e_fire) && !fl;
        e_stall = m_hold && !fl && !e_iv;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_hold = 0; m_instr = '0; m_cnt = 0;
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
        end else begin
            if (bus.wb_en) m_busy[bus.wb_rd] = 0;
            if (e_fire && writes(m_instr[6:2])) m_busy[m_instr[11:7]] = 1;
            m_busy[0] = 0;
            if (e_stall && m_cnt < CNT_MAX) m_cnt++;
            if (bus.flush) m_hold = 0;
            else if (bus.if_valid && e_idr) begin m_hold = 1; m_instr = bus.if_instr; end
            else if (e_fire) m_hold = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 32'd0, 1, 0, 0, 5'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(); tick(); tick();
        rst = 1'b0;
        idle();
        checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got=%0b exp=0", bus.issue_valid); end
        checks++; if (bus.issue_instr !== 32'd0) begin errors++; $display("FAIL reset_issue_instr got=%h exp=0", bus.issue_instr); end
        checks++; if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready got=%0b exp=1", bus.id_ready); end
        checks++; if (bus.sb_busy !== 32'd0) begin errors++; $display("FAIL reset_sb_busy got=%h exp=0", bus.sb_busy); end
        checks++; if (bus.stall_cnt !== '0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", bus.stall_cnt); end
    endtask

    task automatic test_basic();
        drive(1, 32'h00500093, 1, 0, 0, 5'd0);
        checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL basic_latency got=%0b exp=0", bus.issue_valid); end
        tick();
        idle();
        checks++; if (bus.issue_valid !== 1'b1) begin errors++; $display("FAIL basic_issue_valid got=%0b exp=1", bus.issue_valid); end
        checks++; if (bus.issue_instr !== 32'h00500093) begin errors++; $display("FAIL basic_issue_instr got=%h exp=00500093", bus.issue_instr); end
        tick();
        idle();
        checks++; if (bus.sb_busy !== 32'h00000002) begin errors++; $display("FAIL basic_sb_busy got=%h exp=00000002", bus.sb_busy); end
    endtask

    task automatic test_hazard();
        drive(1, 32'h00108133, 1, 0, 0, 5'd0); tick();
        for (int i = 0; i < 3; i++) begin
            idle();
            checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL hazard_stall_iv cyc=%0d got=%0b exp=0", i, bus.issue_valid); end
            checks++; if (bus.stall_cnt !== PERF_W'(i)) begin errors++; $display("FAIL hazard_stall_cnt cyc=%0d got=%0d exp=%0d", i, bus.stall_cnt, i); end
            tick();
        end
        drive(0, 32'd0, 1, 0, 1, 5'd1);
`ifdef ID_WB_BYPASS_EN
        checks++; if (bus.issue_valid !== 1'b1) begin errors++; $display("FAIL hazard_wb_cycle got=%0b exp=1", bus.issue_valid); end
        tick();
`else
        checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL hazard_wb_cycle got=%0b exp=0", bus.issue_valid); end
        tick();
        idle();
        checks++; if (bus.issue_valid !== 1'b1 || bus.issue_instr !== 32'h00108133) begin
            errors++; $display("FAIL hazard_after_wb got=%0b/%h exp=1/00108133", bus.issue_valid, bus.issue_instr); end
        tick();
`endif
        drive(0, 32'd0, 1, 0, 1, 5'd2); tick();
        idle();
        checks++; if (bus.sb_busy !== 32'd0) begin errors++; $display("FAIL hazard_sb_clear got=%h exp=0", bus.sb_busy); end
    endtask

    task automatic test_fence();
        logic [31:0] nxt;
        nxt = mk(O_OPIMM, 5'd4, 5'd0, 5'd0);
        drive(1, 32'h00300193, 1, 0, 0, 5'd0); tick();
        drive(1, 32'h0000000F, 1, 0, 0, 5'd0); tick();
        drive(1, nxt, 1, 0, 0, 5'd0);
        checks++; if (bus.issue_valid !== 1'b0 || bus.id_ready !== 1'b0) begin
            errors++; $display("FAIL fence_drain got=%0b/%0b exp=0/0", bus.issue_valid, bus.id_ready); end
        tick();
        drive(1, nxt, 1, 0, 1, 5'd3);
        checks++; if (bus.issue_valid !== 1'b0 || bus.id_ready !== 1'b0) begin
            errors++; $display("FAIL fence_wb_cycle got=%0b/%0b exp=0/0", bus.issue_valid, bus.id_ready); end
        tick();
        drive(1, nxt, 1, 0, 0, 5'd0);
        checks++; if (bus.issue_valid !== 1'b1 || bus.id_ready !== 1'b1 || bus.issue_instr !== 32'h0000000F) begin
            errors++; $display("FAIL fence_issue got=%0b/%0b/%h exp=1/1/0000000f", bus.issue_valid, bus.id_ready, bus.issue_instr); end
        tick();
        idle();
        checks++; if (bus.issue_valid !== 1'b1 || bus.issue_instr !== nxt) begin
            errors++; $display("FAIL fence_next got=%0b/%h exp=1/%h", bus.issue_valid, bus.issue_instr, nxt); end
        tick();
        drive(0, 32'd0, 1, 0, 1, 5'd4); tick();
    endtask

    task automatic test_flush();
        logic [31:0] sb0;
        drive(1, mk(O_OP, 5'd6, 5'd0, 5'd0), 0, 0, 0, 5'd0); tick();
        sb0 = busy_vec();
        drive(1, mk(O_OPIMM, 5'd7, 5'd0, 5'd0), 0, 1, 0, 5'd0);
        checks++; if (bus.issue_valid !== 1'b0 || bus.id_ready !== 1'b0) begin
            errors++; $display("FAIL flush_cycle got=%0b/%0b exp=0/0", bus.issue_valid, bus.id_ready); end
        tick();
        idle();
        checks++; if (bus.issue_valid !== 1'b0 || bus.id_ready !== 1'b1) begin
            errors++; $display("FAIL flush_after got=%0b/%0b exp=0/1", bus.issue_valid, bus.id_ready); end
        checks++; if (bus.sb_busy !== sb0) begin errors++; $display("FAIL flush_sb got=%h exp=%h", bus.sb_busy, sb0); end
        tick();
    endtask

    task automatic test_sb_rules();
        drive(1, mk(O_OPIMM, 5'd5, 5'd0, 5'd0), 1, 0, 0, 5'd0); tick();
        drive(0, 32'd0, 1, 0, 1, 5'd5); tick();
        drive(0, 32'd0, 1, 0, 1, 5'd0);
        checks++; if (bus.sb_busy[5] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got=%0b exp=1", bus.sb_busy[5]); end
        tick();
        drive(1, 32'h00000037, 1, 0, 0, 5'd0);
        checks++; if (bus.sb_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_x0_wb got=%0b exp=0", bus.sb_busy[0]); end
        tick();
        idle(); tick();
        idle();
        checks++; if (bus.sb_busy !== 32'h00000020) begin errors++; $display("FAIL sb_lui_x0 got=%h exp=00000020", bus.sb_busy); end
        drive(0, 32'd0, 1, 0, 1, 5'd5); tick();
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 8; k++) begin
            drive(1, mk(O_OPIMM, 5'(k), 5'd0, 5'd0), 1, 0, 0, 5'd0);
            checks++; if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL stream_id_ready k=%0d got=%0b exp=1", k, bus.id_ready); end
            if (k > 1) begin
                checks++; if (bus.issue_valid !== 1'b1 || bus.issue_instr !== mk(O_OPIMM, 5'(k-1), 5'd0, 5'd0)) begin
                    errors++; $display("FAIL stream_issue k=%0d got=%0b/%h", k, bus.issue_valid, bus.issue_instr); end
            end
            tick();
        end
        idle(); tick();
        for (int k = 1; k <= 8; k++) begin drive(0, 32'd0, 1, 0, 1, 5'(k)); tick(); end
        idle();
        checks++; if (bus.sb_busy !== 32'd0) begin errors++; $display("FAIL stream_sb_clear got=%h exp=0", bus.sb_busy); end
    endtask

    task automatic test_random();
        logic [4:0] ops [12];
        ops = '{O_LOAD, O_MISC, O_OPIMM, O_AUIPC, O_STORE, O_OP, O_LUI, O_BR, O_JALR, O_JAL, O_SYS, O_OTHER};
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(3) != 0,
                  mk(ops[$urandom_range(11)], 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7))),
                  $urandom_range(3) != 0, $urandom_range(15) == 0,
                  $urandom_range(2) == 0, 5'($urandom_range(7)));
            checks++; if (bus.issue_valid !== e_iv || bus.id_ready !== e_idr) begin
                errors++; $display("FAIL rand_handshake c=%0d got=%0b/%0b exp=%0b/%0b", c, bus.issue_valid, bus.id_ready, e_iv, e_idr); end
            checks++; if (m_hold && bus.issue_instr !== m_instr) begin
                errors++; $display("FAIL rand_instr c=%0d got=%h exp=%h", c, bus.issue_instr, m_instr); end
            checks++; if (bus.sb_busy !== busy_vec()) begin
                errors++; $display("FAIL rand_sb c=%0d got=%h exp=%h", c, bus.sb_busy, busy_vec()); end
            checks++; if (bus.stall_cnt !== PERF_W'(m_cnt)) begin
                errors++; $display("FAIL rand_stall_cnt c=%0d got=%0d exp=%0d", c, bus.stall_cnt, m_cnt); end
            tick();
        end
    endtask

    task automatic test_saturate();
        test_reset();
        drive(1, 32'h00500093, 1, 0, 0, 5'd0); tick();
        drive(1, 32'h00108133, 1, 0, 0, 5'd0); tick();
        for (int i = 0; i < CNT_MAX + 4; i++) begin idle(); tick(); end
        idle();
        checks++; if (bus.stall_cnt !== 16'hFFFF || m_cnt != CNT_MAX) begin
            errors++; $display("FAIL stall_saturate got=%h exp=ffff model=%0d", bus.stall_cnt, m_cnt); end
        checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL stall_saturate_iv got=%0b exp=0", bus.issue_valid); end
        rst = 1'b1; idle(); tick(); rst = 1'b0;
        idle();
        checks++; if (bus.stall_cnt !== '0 || bus.sb_busy !== 32'd0 || bus.issue_valid !== 1'b0) begin
            errors++; $display("FAIL midrun_reset got=%0d/%h/%0b exp=0/0/0", bus.stall_cnt, bus.sb_busy, bus.issue_valid); end
    endtask

    initial begin
        bus.if_valid = 0; bus.if_instr = '0; bus.issue_ready = 0;
        bus.flush = 0; bus.wb_en = 0; bus.wb_rd = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_hazard();
        test_fence();
        test_flush();
        test_sb_rules();
        test_back_to_back();
        test_random();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
